cast_route_table_writer: RTL and testbench

- Runtime writer for the multicast stream route table.
- Accepts configuration commands (WRITE, DELETE, CLEAR) over a valid/ready port and maintains a DEPTH-entry table of {valid, stream_id, output-VC mask}.
- Exposes the same lookup (stream_id -> candidateOutVC) that the router's cast stage consumes, so a router can be reprogrammed without rebuilding its table init file.
- Sits beside each router; driven by the configuration-network endpoint.

---
 rtl/cast_route_table_writer_if.sv | 33 +++
 rtl/cast_route_table_writer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cast_route_table_writer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cast_route_table_writer_if.sv
// Configuration port bundle for cast_route_table_writer.
//   master : configuration-network endpoint (drives commands, consumes responses)
//   slave  : route table writer (accepts commands, returns completion status)
// Signals:
//   cfg_valid/cfg_ready  command handshake
//   cfg_op               00 WRITE, 01 DELETE, 10 CLEAR, 11 READ/illegal
//   cfg_sid, cfg_mask    target stream_id and output-VC mask
//   resp_valid           one-cycle completion pulse
//   resp_status          0 OK, 1 FULL, 2 NOT_FOUND, 3 ILLEGAL
//   resp_mask            readback mask (zero unless READ is built in)
interface cast_route_table_writer_if #(
  parameter int unsigned CN    = 5,
  parameter int unsigned SID_W = 10
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_op;
  logic [SID_W-1:0] cfg_sid;
  logic [CN-1:0]    cfg_mask;
  logic             resp_valid;
  logic [1:0]       resp_status;
  logic [CN-1:0]    resp_mask;

  modport master (
    output cfg_valid, cfg_op, cfg_sid, cfg_mask,
    input  cfg_ready, resp_valid, resp_status, resp_mask
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_sid, cfg_mask,
    output cfg_ready, resp_valid, resp_status, resp_mask
  );
endinterface

// File: rtl/cast_route_table_writer.sv
// Runtime writer for the multicast stream route table.
// Maintains DEPTH entries of {valid, stream_id, output-VC mask} updated by WRITE / DELETE /
// CLEAR commands, and provides the same stream_id -> candidateOutVC lookup that the
// router's cast stage uses.
// Ports:
//   clk             clock
//   rstn            synchronous reset, ACTIVE-HIGH despite its name
//   cfg             command/response bundle (cast_route_table_writer_if.slave)
//   entries_used    number of valid entries
//   stream_id       lookup key
//   candidateOutVC  lookup result (lowest-index valid match, else zero)
// Optional feature: define CAST_RT_READBACK_EN to make op 11 a READ returning the stored
// mask; otherwise op 11 completes with ILLEGAL and resp_mask stays zero.
module cast_route_table_writer #(
  parameter int unsigned CN    = 5,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned SID_W = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  cast_route_table_writer_if.slave     cfg,
  output logic [$clog2(DEPTH+1)-1:0]   entries_used,
  input  logic [SID_W-1:0]             stream_id,
  output logic [CN-1:0]                candidateOutVC
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

  localparam logic [1:0] OpWrite  = 2'b00;
  localparam logic [1:0] OpDelete = 2'b01;
  localparam logic [1:0] OpClear  = 2'b10;
  localparam logic [1:0] OpRead   = 2'b11;

  localparam logic [1:0] StatOk       = 2'd0;
  localparam logic [1:0] StatFull     = 2'd1;
  localparam logic [1:0] StatNotFound = 2'd2;
  localparam logic [1:0] StatIllegal  = 2'd3;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;
  localparam logic [1:0] StClear  = 2'd3;

`ifdef CAST_RT_READBACK_EN
  localparam logic ReadEn = 1'b1;
`else
  localparam logic ReadEn = 1'b0;
`endif

  // Table storage
  logic [DEPTH-1:0] tbl_valid_q;
  logic [SID_W-1:0] tbl_sid_q  [DEPTH];
  logic [CN-1:0]    tbl_mask_q [DEPTH];

  // Control state
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [SID_W-1:0] cmd_sid_q, cmd_sid_d;
  logic [CN-1:0]    cmd_mask_q, cmd_mask_d;
  logic             match_q, match_d;
  logic [IW-1:0]    match_idx_q, match_idx_d;
  logic             free_q, free_d;
  logic [IW-1:0]    free_idx_q, free_idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_status_q, resp_status_d;
  logic [CN-1:0]    resp_mask_q, resp_mask_d;

  // Single table write port; one entry per cycle keeps each update atomic
  logic             tbl_we;
  logic             tbl_wdata;
  logic [IW-1:0]    tbl_widx;
  logic             tbl_wvalid;

  logic             handshake;
  logic             entry_hit;
  logic [CN-1:0]    lookup_mask;

  assign cfg.cfg_ready   = (state_q == StIdle) && !rstn;
  assign handshake       = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg.resp_valid  = resp_valid_q;
  assign cfg.resp_status = resp_status_q;
  assign cfg.resp_mask   = resp_mask_q;
  assign entries_used    = count_q;

  assign entry_hit = tbl_valid_q[idx_q] && (tbl_sid_q[idx_q] == cmd_sid_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    op_d          = op_q;
    cmd_sid_d     = cmd_sid_q;
    cmd_mask_d    = cmd_mask_q;
    match_d       = match_q;
    match_idx_d   = match_idx_q;
    free_d        = free_q;
    free_idx_d    = free_idx_q;
    count_d       = count_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    resp_mask_d   = resp_mask_q;
    tbl_we        = 1'b0;
    tbl_wdata     = 1'b0;
    tbl_widx      = idx_q;
    tbl_wvalid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          op_d       = cfg.cfg_op;
          cmd_sid_d  = cfg.cfg_sid;
          cmd_mask_d = cfg.cfg_mask;
          idx_d      = '0;
          match_d    = 1'b0;
          free_d     = 1'b0;
          if (cfg.cfg_op == OpClear) begin
            state_d = StClear;
          end else if (cfg.cfg_op == OpRead && !ReadEn) begin
            state_d = StCommit;
          end else begin
            state_d = StSearch;
          end
        end
      end

      StSearch: begin
        if (entry_hit) begin
          match_d     = 1'b1;
          match_idx_d = idx_q;
          state_d     = StCommit;
        end else begin
          if (!tbl_valid_q[idx_q] && !free_q) begin
            free_d     = 1'b1;
            free_idx_d = idx_q;
          end
          if (idx_q == LastIdx) begin
            state_d = StCommit;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      StCommit: begin
        state_d      = StIdle;
        resp_valid_d = 1'b1;
        resp_mask_d  = '0;
        case (op_q)
          OpWrite: begin
            if (match_q) begin
              tbl_we        = 1'b1;
              tbl_wdata     = 1'b1;
              tbl_widx      = match_idx_q;
              tbl_wvalid    = 1'b1;
              resp_status_d = StatOk;
            end else if (free_q) begin
              tbl_we        = 1'b1;
              tbl_wdata     = 1'b1;
              tbl_widx      = free_idx_q;
              tbl_wvalid    = 1'b1;
              count_d       = count_q + CW'(1);
              resp_status_d = StatOk;
            end else begin
              resp_status_d = StatFull;
            end
          end
          OpDelete: begin
            if (match_q) begin
              tbl_we        = 1'b1;
              tbl_widx      = match_idx_q;
              tbl_wvalid    = 1'b0;
              count_d       = count_q - CW'(1);
              resp_status_d = StatOk;
            end else begin
              resp_status_d = StatNotFound;
            end
          end
          default: begin
            if (op_q == OpRead && ReadEn) begin
              resp_mask_d   = match_q ? tbl_mask_q[match_idx_q] : '0;
              resp_status_d = match_q ? StatOk : StatNotFound;
            end else begin
              resp_status_d = StatIllegal;
            end
          end
        endcase
      end

      StClear: begin
        tbl_we     = 1'b1;
        tbl_wvalid = 1'b0;
        if (idx_q == LastIdx) begin
          state_d       = StIdle;
          count_d       = '0;
          resp_valid_d  = 1'b1;
          resp_status_d = StatOk;
          resp_mask_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      op_q          <= OpWrite;
      cmd_sid_q     <= '0;
      cmd_mask_q    <= '0;
      match_q       <= 1'b0;
      match_idx_q   <= '0;
      free_q        <= 1'b0;
      free_idx_q    <= '0;
      count_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= StatOk;
      resp_mask_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      op_q          <= op_d;
      cmd_sid_q     <= cmd_sid_d;
      cmd_mask_q    <= cmd_mask_d;
      match_q       <= match_d;
      match_idx_q   <= match_idx_d;
      free_q        <= free_d;
      free_idx_q    <= free_idx_d;
      count_q       <= count_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_mask_q   <= resp_mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      tbl_valid_q <= '0;
    end else if (tbl_we) begin
      tbl_valid_q[tbl_widx] <= tbl_wvalid;
    end
  end

  // sid/mask need no reset: every read of them is qualified by the valid bit
  always_ff @(posedge clk) begin
    if (!rstn && tbl_we && tbl_wdata) begin
      tbl_sid_q[tbl_widx]  <= cmd_sid_q;
      tbl_mask_q[tbl_widx] <= cmd_mask_q;
    end
  end

  // Lowest index wins when several entries could match
  always_comb begin
    lookup_mask = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (tbl_valid_q[i] && tbl_sid_q[i] == stream_id) begin
        lookup_mask = tbl_mask_q[i];
      end
    end
  end

  assign candidateOutVC = rstn ? '0 : lookup_mask;

endmodule

// File: tb/tb_cast_route_table_writer.sv
module tb_cast_route_table_writer;

  localparam int unsigned CN    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned SID_W = 10;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_DEL = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  localparam int ST_OK = 0, ST_FULL = 1, ST_NF = 2, ST_ILL = 3;

`ifdef CAST_RT_READBACK_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic             clk;
  logic             rstn;
  logic [CW-1:0]    entries_used;
  logic [SID_W-1:0] stream_id;
  logic [CN-1:0]    candidateOutVC;

  cast_route_table_writer_if #(.CN(CN), .SID_W(SID_W)) cfg_if ();

  cast_route_table_writer #(.CN(CN), .DEPTH(DEPTH), .SID_W(SID_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cfg            (cfg_if),
    .entries_used   (entries_used),
    .stream_id      (stream_id),
    .candidateOutVC (candidateOutVC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the table as the command semantics describe it
  bit               mv [DEPTH];
  logic [SID_W-1:0] ms [DEPTH];
  logic [CN-1:0]    mm [DEPTH];
  int               mcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [SID_W-1:0] sid);
    for (int i = 0; i < int'(DEPTH); i++) if (mv[i] && ms[i] == sid) return i;
    return -1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < int'(DEPTH); i++) if (!mv[i]) return i;
    return -1;
  endfunction

  function automatic logic [CN-1:0] m_lookup(input logic [SID_W-1:0] sid);
    int k;
    k = m_find(sid);
    return (k >= 0) ? mm[k] : '0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < int'(DEPTH); i++) mv[i] = 1'b0;
    mcount = 0;
  endtask

  task automatic check_lookup(input string tag, input logic [SID_W-1:0] sid);
    stream_id = sid;
    #1;
    chk(tag, 32'(candidateOutVC), 32'(m_lookup(sid)));
  endtask

  // Issue one command, measure latency from the handshake cycle, and compare against the model
  task automatic run_cmd(input logic [1:0] op, input logic [SID_W-1:0] sid,
                         input logic [CN-1:0] mask);
    int k, f, exp_lat, exp_st, lat, w;
    logic [CN-1:0] exp_mask;
    k = m_find(sid);
    f = m_free();
    exp_mask = '0;
    if (op == OP_CLR) begin
      exp_lat = DEPTH + 1; exp_st = ST_OK; m_clear();
    end else if (op == OP_RD && !READ_EN) begin
      exp_lat = 2; exp_st = ST_ILL;
    end else begin
      exp_lat = (k >= 0) ? k + 3 : int'(DEPTH) + 2;
      if (op == OP_WR) begin
        if (k >= 0) begin
          mm[k] = mask; exp_st = ST_OK;
        end else if (f >= 0) begin
          mv[f] = 1'b1; ms[f] = sid; mm[f] = mask; mcount++; exp_st = ST_OK;
        end else begin
          exp_st = ST_FULL;
        end
      end else if (op == OP_DEL) begin
        if (k >= 0) begin
          mv[k] = 1'b0; mcount--; exp_st = ST_OK;
        end else begin
          exp_st = ST_NF;
        end
      end else begin
        exp_st = (k >= 0) ? ST_OK : ST_NF;
        exp_mask = (k >= 0) ? mm[k] : '0;
      end
    end

    @(negedge clk);
    w = 0;
    while (!cfg_if.cfg_ready && w < 4 * int'(DEPTH)) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_cmd", 32'(cfg_if.cfg_ready), 32'd1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_op    = op;
    cfg_if.cfg_sid   = sid;
    cfg_if.cfg_mask  = mask;
    @(posedge clk);
    #1;
    // Fields only need to be stable in the handshake cycle
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_op    = 2'($urandom);
    cfg_if.cfg_sid   = SID_W'($urandom);
    cfg_if.cfg_mask  = CN'($urandom);
    lat = 1;
    while (!cfg_if.resp_valid && lat < 3 * int'(DEPTH)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_status", 32'(cfg_if.resp_status), 32'(exp_st));
    chk("resp_mask", 32'(cfg_if.resp_mask), 32'(exp_mask));
    chk("ready_in_resp", 32'(cfg_if.cfg_ready), 32'd1);
    chk("entries_used", 32'(entries_used), 32'(mcount));
    check_lookup("lookup_cmd_sid", sid);
    @(posedge clk);
    #1;
    chk("resp_pulse_width", 32'(cfg_if.resp_valid), 32'd0);
  endtask

  logic [SID_W-1:0] sid3;

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_op    = OP_WR;
    cfg_if.cfg_sid   = '0;
    cfg_if.cfg_mask  = '0;
    stream_id        = '0;
    m_clear();

    // Reset state
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("rst_resp_valid", 32'(cfg_if.resp_valid), 32'd0);
    chk("rst_resp_status", 32'(cfg_if.resp_status), 32'd0);
    chk("rst_resp_mask", 32'(cfg_if.resp_mask), 32'd0);
    chk("rst_entries", 32'(entries_used), 32'd0);
    chk("rst_candidate", 32'(candidateOutVC), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_if.cfg_ready), 32'd1);

    // First write (empty table, no match: full search), overwrite, lookups
    run_cmd(OP_WR, 10'd5, 5'b00110);
    check_lookup("lookup_5", 10'd5);
    chk("lookup_5_const", 32'(candidateOutVC), 32'b00110);
    check_lookup("lookup_6", 10'd6);
    run_cmd(OP_WR, 10'd5, 5'b10001);
    chk("overwrite_lookup", 32'(candidateOutVC), 32'b10001);
    chk("overwrite_count", 32'(entries_used), 32'd1);

    // Fill to DEPTH, then a WRITE must report FULL
    for (int i = 1; i < int'(DEPTH); i++) run_cmd(OP_WR, SID_W'(100 + i), CN'($urandom));
    chk("full_count", 32'(entries_used), 32'(DEPTH));
    run_cmd(OP_WR, 10'd999, 5'b11111);
    chk("full_lookup_999", 32'(candidateOutVC), 32'd0);

    // Freed index 3 is reused by the next new sid
    sid3 = ms[3];
    run_cmd(OP_DEL, sid3, 5'b0);
    run_cmd(OP_WR, 10'd777, 5'b01011);
    chk("reuse_lookup_777", 32'(candidateOutVC), 32'b01011);
    run_cmd(OP_DEL, 10'd888, 5'b0);
    // Zero mask keeps the entry alive
    run_cmd(OP_WR, 10'd777, 5'b00000);
    chk("zero_mask_count", 32'(entries_used), 32'(DEPTH));

    // CLEAR a full table
    run_cmd(OP_CLR, 10'd0, 5'b0);
    check_lookup("clear_lookup_5", 10'd5);
    check_lookup("clear_lookup_777", 10'd777);

    // Reset while searching: no response, table emptied
    run_cmd(OP_WR, 10'd40, 5'b00011);
    run_cmd(OP_WR, 10'd41, 5'b00101);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_op    = OP_WR;
    cfg_if.cfg_sid   = 10'd42;
    cfg_if.cfg_mask  = 5'b1;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    m_clear();
    begin
      int seen = 0;
      for (int c = 0; c < int'(DEPTH) + 4; c++) begin
        @(negedge clk);
        if (cfg_if.resp_valid) seen++;
      end
      chk("abort_no_resp", 32'(seen), 32'd0);
    end
    chk("abort_entries", 32'(entries_used), 32'd0);
    check_lookup("abort_lookup_40", 10'd40);

    // Op 11 on a stored sid
    run_cmd(OP_WR, 10'd5, 5'b00110);
    run_cmd(OP_RD, 10'd5, 5'b0);

    // Randomized traffic over a sid pool larger than the table
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 99);
      op = (r < 50) ? OP_WR : (r < 80) ? OP_DEL : (r < 96) ? OP_RD : OP_CLR;
      run_cmd(op, SID_W'($urandom_range(0, 47)), CN'($urandom));
      check_lookup("rand_lookup", SID_W'($urandom_range(0, 47)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
